// File: rtl/sd_sector_dma.sv
// Streams one 512-byte SD sector into BRAM as 128 little-endian 32-bit words, sharing the
// BRAM write port with the CPU. Optional idle watchdog enabled by defining SD_DMA_TIMEOUT_EN.
`timescale 1ns / 1ps
module sd_sector_dma #(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned WAIT_MAX       = 15,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic              cfg_re,
  input  logic [1:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       cfg_rdata,
  output logic              cfg_rvalid,
  output logic              sd_rd,
  output logic [31:0]       sd_address,
  input  logic              sd_ready,
  input  logic              sd_byte_available,
  input  logic [7:0]        sd_dout,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_grant,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              irq_done
);

  localparam int unsigned WaitW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(WAIT_MAX);

  typedef enum logic [1:0] {StIdle, StWaitRdy, StCollect, StDone} state_e;

  state_e            state_q;
  logic [31:0]       sector_q;
  logic [ADDR_W-1:0] dest_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [9:0]        count_q;
  logic              busy_q, done_q, err_q;
  logic [23:0]       pack_q;
  logic [31:0]       pend_word_q;
  logic              pending_q;
  logic [WaitW-1:0]  wait_q;
  logic              avail_q;

  logic dma_fire;
  logic byte_edge;
  logic wd_expire;

  assign byte_edge = (state_q == StCollect) && sd_byte_available && !avail_q &&
                     (count_q < 10'd512);

  // DMA wins when the CPU is idle or has already starved it for WAIT_MAX cycles.
  always_comb begin
    dma_fire  = !reset && pending_q && (!cpu_req || (wait_q == WaitMax));
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_grant = 1'b0;
    if (dma_fire) begin
      mem_we    = 1'b1;
      mem_addr  = ptr_q;
      mem_wdata = pend_word_q;
    end else if (!reset && cpu_req) begin
      mem_we    = 1'b1;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      cpu_grant = 1'b1;
    end
  end

`ifdef SD_DMA_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

  logic [WdW-1:0] wd_q;
  logic           ready_q;
  logic           wd_active, wd_progress;

  assign wd_active   = (state_q == StWaitRdy) || (state_q == StCollect);
  assign wd_progress = (sd_ready && !ready_q) || byte_edge;
  assign wd_expire   = wd_active && !wd_progress && (wd_q == WdLast);

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q    <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= sd_ready;
      if (!wd_active || wd_progress || wd_expire) begin
        wd_q <= '0;
      end else begin
        wd_q <= wd_q + WdW'(1);
      end
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      sector_q    <= '0;
      dest_q      <= '0;
      ptr_q       <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pack_q      <= '0;
      pend_word_q <= '0;
      pending_q   <= 1'b0;
      wait_q      <= '0;
      avail_q     <= 1'b0;
      cfg_rdata   <= '0;
      cfg_rvalid  <= 1'b0;
      sd_rd       <= 1'b0;
      sd_address  <= '0;
      irq_done    <= 1'b0;
    end else begin
      sd_rd      <= 1'b0;
      irq_done   <= 1'b0;
      cfg_rvalid <= cfg_re;
      avail_q    <= sd_byte_available;

      if (cfg_re) begin
        case (cfg_addr)
          2'd0:    cfg_rdata <= sector_q;
          2'd1:    cfg_rdata <= {{(32 - ADDR_W){1'b0}}, dest_q};
          2'd2:    cfg_rdata <= {29'b0, err_q, done_q, busy_q};
          default: cfg_rdata <= {22'b0, count_q};
        endcase
      end

      if (cfg_we) begin
        case (cfg_addr)
          2'd0: if (!busy_q) sector_q <= cfg_wdata;
          2'd1: if (!busy_q) dest_q <= cfg_wdata[ADDR_W-1:0];
          2'd2: if (cfg_wdata[1]) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
          end
          default: ;
        endcase
      end

      if (dma_fire) begin
        ptr_q     <= ptr_q + ADDR_W'(1);
        pending_q <= 1'b0;
        wait_q    <= '0;
      end else if (pending_q) begin
        wait_q <= wait_q + WaitW'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (cfg_we && (cfg_addr == 2'd2) && cfg_wdata[0] && !busy_q) begin
            busy_q  <= 1'b1;
            count_q <= '0;
            ptr_q   <= dest_q;
            pack_q  <= '0;
            state_q <= StWaitRdy;
          end
        end
        StWaitRdy: begin
          if (sd_ready) begin
            sd_rd      <= 1'b1;
            sd_address <= sector_q;
            state_q    <= StCollect;
          end
        end
        StCollect: begin
          if (byte_edge) begin
            count_q <= count_q + 10'd1;
            unique case (count_q[1:0])
              2'd0: pack_q[7:0]   <= sd_dout;
              2'd1: pack_q[15:8]  <= sd_dout;
              2'd2: pack_q[23:16] <= sd_dout;
              default: begin
                // A word completing while the previous one still waits is an overflow,
                // unless that previous word drains on this very edge.
                if (pending_q && !dma_fire) begin
                  err_q     <= 1'b1;
                  pending_q <= 1'b0;
                  state_q   <= StDone;
                end else begin
                  pend_word_q <= {sd_dout, pack_q};
                  pending_q   <= 1'b1;
                end
              end
            endcase
          end
          if ((count_q == 10'd512) && !pending_q) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          irq_done <= 1'b1;
          state_q  <= StIdle;
        end
      endcase

      if (wd_expire) begin
        err_q     <= 1'b1;
        pending_q <= 1'b0;
        pack_q    <= '0;
        state_q   <= StDone;
      end
    end
  end

endmodule
